// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes and {V,C,N,Z} status flags.

package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_MOV = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } alu_flags_t;

endpackage

module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned SHW    = $clog2(DWIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_func,
    input  logic [DWIDTH-1:0] alu_a,
    input  logic [DWIDTH-1:0] alu_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] alu_out,
    output logic [3:0]        flags
);

    localparam int unsigned MSB = DWIDTH - 1;

    // Stage 1: captured request
    logic              s1_valid;
    alu_op_e           s1_func;
    logic [DWIDTH-1:0] s1_a;
    logic [DWIDTH-1:0] s1_b;

    // Stage 2: registered result
    logic              s2_valid;
    logic [DWIDTH-1:0] s2_res;
    alu_flags_t        s2_flags;

    // Handshake controls
    logic s2_load;
    logic s1_load;
    logic in_xfer;

    // Stage 2 datapath (combinational, from stage 1 registers)
    logic [DWIDTH-1:0] res_c;
    alu_flags_t        flags_c;
    logic [DWIDTH:0]   sum_w;
    logic [DWIDTH:0]   diff_w;
    logic [DWIDTH:0]   shl_w;
    logic [DWIDTH:0]   shr_w;
    logic [SHW-1:0]    sh_amt;
    logic              sh_big;

    // Pipeline advance: S2 moves when empty or drained; S1 moves when empty or S2 moves
    always_comb begin
        s2_load  = !s2_valid || out_ready;
        s1_load  = !s1_valid || s2_load;
        in_ready = !s1_valid || !s2_valid || out_ready;
        in_xfer  = in_valid && in_ready;
    end

    // Stage 1 register: operands and opcode on input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_func  <= OP_MOV;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_xfer;
            if (in_xfer) begin
                s1_func <= alu_op_e'(alu_func);
                s1_a    <= alu_a;
                s1_b    <= alu_b;
            end
        end
    end

    // Result and flag computation for the op held in stage 1
    always_comb begin
        sum_w  = {1'b0, s1_a} + {1'b0, s1_b};
        diff_w = {1'b0, s1_a} - {1'b0, s1_b};
        sh_amt = s1_b[SHW-1:0];
        // Amount out of range: any upper bit set, or field >= DWIDTH for odd widths
        sh_big = (s1_b[DWIDTH-1:SHW] != '0) || (32'(sh_amt) >= DWIDTH);
        // Extra bit above/below the result catches the last bit shifted out
        shl_w  = {1'b0, s1_a} << sh_amt;
        shr_w  = {s1_a, 1'b0} >> sh_amt;

        res_c   = '0;
        flags_c = '0;

        case (s1_func)
            OP_MOV: res_c = s1_b;
            OP_ADD: begin
                res_c     = sum_w[DWIDTH-1:0];
                flags_c.c = sum_w[DWIDTH];
                flags_c.v = (s1_a[MSB] == s1_b[MSB]) && (sum_w[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                res_c     = diff_w[DWIDTH-1:0];
                flags_c.c = diff_w[DWIDTH];
                flags_c.v = (s1_a[MSB] != s1_b[MSB]) && (diff_w[MSB] != s1_a[MSB]);
            end
            OP_AND: res_c = s1_a & s1_b;
            OP_OR:  res_c = s1_a | s1_b;
            OP_XOR: res_c = s1_a ^ s1_b;
            OP_SHL: begin
                if (!sh_big) begin
                    res_c     = shl_w[DWIDTH-1:0];
                    flags_c.c = shl_w[DWIDTH];
                end
            end
            OP_SHR: begin
                if (!sh_big) begin
                    res_c     = shr_w[DWIDTH:1];
                    flags_c.c = shr_w[0];
                end
            end
            default: res_c = '0;
        endcase

        flags_c.n = res_c[MSB];
        flags_c.z = (res_c == '0);
    end

    // Stage 2 register: holds result stable while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_flags <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res   <= res_c;
                s2_flags <= flags_c;
            end
        end
    end

    // Outputs come straight from stage 2 registers
    always_comb begin
        out_valid = s2_valid;
        alu_out   = s2_res;
        flags     = s2_flags;
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed, table-driven check of alu_pipe at DWIDTH=16.

module tb_alu_pipe;

    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    alu_func;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] alu_out;
    logic [3:0]    flags;

    int n_tests = 0;
    int n_fail  = 0;

    alu_pipe #(.DWIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_func  (alu_func),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    func;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
        logic [3:0]    fl;   // {V,C,N,Z}
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op with out_ready=1 and check 2-edge latency, result and flags
    task automatic run_op(input string name, input vec_t v);
        @(negedge clk);
        in_valid = 1'b1;
        alu_func = v.func;
        alu_a    = v.a;
        alu_b    = v.b;
        check({name, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({name, " early_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({name, " out_valid"}, 64'(out_valid), 64'd1);
        check({name, " alu_out"}, 64'(alu_out), 64'(v.res));
        check({name, " flags"}, 64'(flags), 64'(v.fl));
    endtask

    initial begin
        vec_t          sv [8];
        logic [DW-1:0] held_out;
        logic [3:0]    held_fl;

        //          func    a         b         res       {V,C,N,Z}
        vecs[0]  = '{3'd1, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010};
        vecs[1]  = '{3'd1, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101};
        vecs[2]  = '{3'd2, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110};
        vecs[3]  = '{3'd2, 16'h8000, 16'h0001, 16'h7FFF, 4'b1000};
        vecs[4]  = '{3'd5, 16'hF0F0, 16'hFF00, 16'h0FF0, 4'b0000};
        vecs[5]  = '{3'd6, 16'h8001, 16'h0001, 16'h0002, 4'b0100};
        vecs[6]  = '{3'd7, 16'h0003, 16'h0001, 16'h0001, 4'b0100};
        vecs[7]  = '{3'd6, 16'h1234, 16'h0010, 16'h0000, 4'b0001};
        vecs[8]  = '{3'd0, 16'h1234, 16'h0000, 16'h0000, 4'b0001};
        vecs[9]  = '{3'd3, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
        vecs[10] = '{3'd4, 16'h8000, 16'h0001, 16'h8001, 4'b0010};
        vecs[11] = '{3'd7, 16'h8000, 16'h000F, 16'h0001, 4'b0000};
        vecs[12] = '{3'd6, 16'h0001, 16'h000F, 16'h8000, 4'b0010};
        vecs[13] = '{3'd7, 16'h1234, 16'h0100, 16'h0000, 4'b0001};
        vecs[14] = '{3'd7, 16'h800F, 16'h0004, 16'h0800, 4'b0100};
        vecs[15] = '{3'd2, 16'h0005, 16'h0005, 16'h0000, 4'b0001};
        vecs[16] = '{3'd1, 16'h8000, 16'h8000, 16'h0000, 4'b1101};
        vecs[17] = '{3'd0, 16'h0000, 16'hABCD, 16'hABCD, 4'b0010};

        // Reset with garbage on the inputs
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        alu_func  = 3'($urandom);
        alu_a     = 16'($urandom);
        alu_b     = 16'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst alu_out", 64'(alu_out), 64'd0);
        check("rst flags", 64'(flags), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle out_valid", 64'(out_valid), 64'd0);
        end

        // Single ops from the table
        for (int i = 0; i < NVEC; i++)
            run_op($sformatf("vec%0d", i), vecs[i]);
        @(negedge clk);

        // Streaming: 8 back-to-back ADDs, results at negedge c for op c-2
        for (int i = 0; i < 8; i++)
            sv[i] = '{3'd1, 16'(i * 16'h1111), 16'(i + 1), 16'(i * 16'h1111 + i + 1), 4'b0000};
        sv[7].fl = 4'b0010;  // 0x7777+8 = 0x777F, N=0 ... corrected below
        sv[7].fl = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check($sformatf("stream%0d valid", c - 2), 64'(out_valid), 64'd1);
                check($sformatf("stream%0d out", c - 2), 64'(alu_out), 64'(sv[c-2].res));
            end else begin
                check($sformatf("stream pre%0d valid", c), 64'(out_valid), 64'd0);
            end
            if (c < 8) begin
                in_valid = 1'b1;
                alu_func = sv[c].func;
                alu_a    = sv[c].a;
                alu_b    = sv[c].b;
                check($sformatf("stream%0d in_ready", c), 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("stream drained", 64'(out_valid), 64'd0);

        // Backpressure: three ops with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_func  = vecs[0].func; alu_a = vecs[0].a; alu_b = vecs[0].b;
        @(posedge clk);
        @(negedge clk);
        check("bp in_ready1", 64'(in_ready), 64'd1);
        alu_func  = vecs[4].func; alu_a = vecs[4].a; alu_b = vecs[4].b;
        @(posedge clk);
        @(negedge clk);
        check("bp in_ready2", 64'(in_ready), 64'd0);
        check("bp valid", 64'(out_valid), 64'd1);
        check("bp out A", 64'(alu_out), 64'(vecs[0].res));
        held_out = alu_out;
        held_fl  = flags;
        alu_func  = vecs[5].func; alu_a = vecs[5].a; alu_b = vecs[5].b;
        repeat (2) begin
            @(negedge clk);
            check("bp stall in_ready", 64'(in_ready), 64'd0);
            check("bp stall valid", 64'(out_valid), 64'd1);
            check("bp stall out", 64'(alu_out), 64'(held_out));
            check("bp stall flags", 64'(flags), 64'(held_fl));
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp out B valid", 64'(out_valid), 64'd1);
        check("bp out B", 64'(alu_out), 64'(vecs[4].res));
        @(negedge clk);
        check("bp out C valid", 64'(out_valid), 64'd1);
        check("bp out C", 64'(alu_out), 64'(vecs[5].res));
        check("bp out C flags", 64'(flags), 64'(vecs[5].fl));
        @(negedge clk);
        check("bp drained", 64'(out_valid), 64'd0);

        // Mid-stream reset with two ops in flight
        in_valid = 1'b1;
        alu_func = vecs[2].func; alu_a = vecs[2].a; alu_b = vecs[2].b;
        @(negedge clk);
        alu_func = vecs[3].func; alu_a = vecs[3].a; alu_b = vecs[3].b;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid pre valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid async valid", 64'(out_valid), 64'd0);
        check("mid async out", 64'(alu_out), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mid post valid", 64'(out_valid), 64'd0);
        end
        run_op("mid new", vecs[16]);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined ALU with a valid/ready handshake on input and output. It generalises the single-cycle enable-driven ALU with configurable width, three new operations (XOR, SHL, SHR), a status-flag output and full backpressure. It sits between the instruction decode/operand fetch stage and the writeback stage of the datapath.

## Interface
- DWIDTH, 16: operand and result width; legal range 4..64.
- SHW, $clog2(DWIDTH): width of the shift-amount field taken from alu_b.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request this cycle.
- alu_func  input  3  opcode: 000 MOV, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 SHL, 111 SHR.
- alu_a, alu_b  input  DWIDTH  operands.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result this cycle.
- alu_out  output  DWIDTH  result.
- flags  output  4  {V, C, N, Z}.

## Operation
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage 1 (S1): registers func, a, b and a valid bit on input transfer.
- Stage 2 (S2): computes the result and flags from S1, registers them with a valid bit; drives alu_out, flags and out_valid directly from registers.
- S2 loads from S1 when S2 is empty or out_ready is high; on load, S2 valid takes S1 valid.
- S1 loads when S1 is empty or S2 loads; S1 valid takes in_valid && in_ready.
- in_ready = !s1_valid || !s2_valid || out_ready (combinational; it must not depend on in_valid).
- Results:
  - MOV: b.
  - ADD: a+b mod 2^DWIDTH.
  - SUB: a-b mod 2^DWIDTH.
  - AND, OR, XOR: bitwise.
  - SHL: a << b[SHW-1:0], zero fill.
  - SHR: a >> b[SHW-1:0], logical.
  - For SHL and SHR, if b >= DWIDTH (any upper bit set, or the amount field >= DWIDTH for non-power-of-2 widths), the result is 0.
- Flags:
  - Z = (result == 0), all ops.
  - N = result[DWIDTH-1], all ops.
  - C: ADD carry out of bit DWIDTH-1; SUB borrow (a < b, unsigned); SHL last bit shifted out (0 if amount is 0 or >= DWIDTH+1 is irrelevant: amount >= DWIDTH gives C=0); SHR last bit shifted out (same rule); else 0.
  - V: ADD signed overflow (a, b same sign, result sign differs); SUB signed overflow (a, b differ in sign, result sign differs from a); else 0.
- A stalled output (out_valid && !out_ready) holds alu_out, flags and out_valid stable until transferred.
- There are no illegal opcodes; all 8 encodings are defined.

## Timing
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, alu_out=0, flags=0, internal operand registers 0. in_ready=1 during and after reset.
- Latency: a request accepted at edge k gives out_valid=1 after edge k+1 (result visible in the cycle following the second edge).
- Throughput: 1 op/cycle while out_ready=1.
- Buffering: with out_ready=0, at most 2 ops are held (S1+S2); in_ready drops to 0 only when both are full and out_ready=0.
- Simultaneous input and output transfer on a full pipe: S2 takes S1, S1 takes the new op, with no bubble and no loss.
- Payload registers may load unconditionally when their stage is empty; valid bits gate visibility. Outputs reflect S2 registers only.
- Reset mid-operation: all in-flight ops are discarded; out_valid falls asynchronously and no partial result is presented after release.

## Test plan
- Reset/idle: hold rst_n=0 with random inputs -> out_valid=0, alu_out=0, flags=0, in_ready=1; after release with no in_valid, out_valid stays 0.
- Arithmetic flags (DWIDTH=16): ADD 0x7FFF+0x0001 -> 0x8000, V=1 C=0 N=1 Z=0; ADD 0xFFFF+0x0001 -> 0x0000, C=1 Z=1 V=0; SUB 0x0003-0x0005 -> 0xFFFE, C=1 N=1; SUB 0x8000-0x0001 -> 0x7FFF, V=1.
- Logic/shift: XOR 0xF0F0^0xFF00 -> 0x0FF0; SHL 0x8001 by 1 -> 0x0002, C=1; SHR 0x0003 by 1 -> 0x0001, C=1; SHL 0x1234 by 16 -> 0x0000, Z=1, C=0; MOV b=0x0000 -> Z=1.
- Streaming: 8 back-to-back ops with out_ready=1 -> 8 results in order, first at cycle 2, one per cycle thereafter, in_ready constantly 1.
- Backpressure: out_ready=0 while issuing 3 ops -> 2 accepted, in_ready=0 on the third, outputs stable; raise out_ready -> all 3 delivered in order, none duplicated or dropped.
- Mid-stream reset: assert rst_n=0 with 2 ops in flight -> out_valid=0 immediately; after release, no stale results appear and a new op returns correctly 2 cycles after acceptance.
